// File: rtl/freq_meas_sched.sv
// Round-robin scheduler sharing one gated frequency counter among NCH test-clock channels.
// Picks a channel, lets the clock mux settle, opens the gate window, then publishes the tagged count.
module freq_meas_sched #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_CYC    = 125_000_000,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             refclk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   req_i,
  output logic [CH_W-1:0]  sel_o,
  output logic             gate_o,
  input  logic [CNT_W-1:0] count_i,
  input  logic             count_vld_i,
  output logic [CNT_W-1:0] result_o,
  output logic [CH_W-1:0]  result_ch_o,
  output logic             result_vld_o,
  output logic             result_err_o,
  output logic             busy_o
);

  // state  | meaning
  // IDLE   | no measurement running; grants the next requester round-robin
  // SETTLE | mux select applied, gate held low while the selected clock settles
  // GATE   | gate_o high, counter accumulating test-clock edges
  // WAIT   | gate closed, waiting for the counter's result or the timeout

  localparam int MAX_A   = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, WAIT} state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [CH_W-1:0] last;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] idx;
  logic            found;

  // Search starts just after the last granted channel so every requester gets a turn.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CH_W'((int'(last) + i) % NCH);
      if (!found && req_i[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tmr          <= '0;
      last         <= CH_W'(NCH - 1);
      sel_o        <= '0;
      gate_o       <= 1'b0;
      result_o     <= '0;
      result_ch_o  <= '0;
      result_vld_o <= 1'b0;
      result_err_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      result_vld_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel_o  <= grant;
            last   <= grant;
            tmr    <= TW'(SETTLE_CYC - 1);
            busy_o <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            gate_o <= 1'b1;
            tmr    <= TW'(GATE_CYC - 1);
            state  <= GATE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GATE: begin
          if (tmr == '0) begin
            gate_o <= 1'b0;
            tmr    <= TW'(TIMEOUT_CYC - 1);
            state  <= WAIT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WAIT: begin
          // A valid count arriving on the last timeout cycle still wins.
          if (count_vld_i || tmr == '0) begin
            result_o     <= count_vld_i ? count_i : '0;
            result_err_o <= !count_vld_i;
            result_ch_o  <= sel_o;
            result_vld_o <= 1'b1;
            busy_o       <= 1'b0;
            tmr          <= '0;
            state        <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
